// File: rtl/temp_pkg.sv
// temp_pkg: shared definitions for the on-die temperature sensor reader.
//   TEMP_W          - width of a sensor reading
//   *_DEF           - default pacing parameters for temp_sensor_reader
//   state_e         - handshake FSM states
package temp_pkg;

  localparam int TEMP_W         = 10;
  localparam int PERIOD_CYC_DEF = 4096;
  localparam int CS_LOW_CYC_DEF = 8;
  localparam int STABLE_CNT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CS_LOW  = 3'd4,
    ST_CS_HIGH = 3'd5
  } state_e;

endpackage

// File: rtl/temp_hyst_track.sv
// temp_hyst_track: running maximum and hysteresis alarm over a strobed sample
// stream. Shared with the voltage monitor, hence the width parameter.
//   clk_i, rst_n_i   - clock, async active-low reset
//   sample_i         - value being captured this cycle
//   sample_vld_i     - capture strobe (result visible the next cycle)
//   thr_hi_i/lo_i    - alarm set / clear thresholds (unsigned, lo <= hi)
//   clr_max_i        - clear running maximum
//   max_o, over_o    - registered running maximum and alarm
module temp_hyst_track #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] sample_i,
  input  logic         sample_vld_i,
  input  logic [W-1:0] thr_hi_i,
  input  logic [W-1:0] thr_lo_i,
  input  logic         clr_max_i,
  output logic [W-1:0] max_o,
  output logic         over_o
);

  logic [W-1:0] max_q, max_d;
  logic         over_q, over_d;

  // Next maximum / alarm; a capture coinciding with a clear restarts the
  // maximum from the captured value rather than from zero.
  always_comb begin
    max_d  = max_q;
    over_d = over_q;
    if (sample_vld_i) begin
      if (clr_max_i || (sample_i > max_q)) begin
        max_d = sample_i;
      end else begin
        max_d = max_q;
      end
      if (sample_i > thr_hi_i) begin
        over_d = 1'b1;
      end else if (sample_i < thr_lo_i) begin
        over_d = 1'b0;
      end else begin
        over_d = over_q;
      end
    end else if (clr_max_i) begin
      max_d = '0;
    end else begin
      max_d = max_q;
    end
  end

  // Tracking registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      max_q  <= '0;
      over_q <= 1'b0;
    end else begin
      max_q  <= max_d;
      over_q <= over_d;
    end
  end

  assign max_o  = max_q;
  assign over_o = over_q;

endmodule

// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader: paces sensor conversions with a CS low pulse, captures
// the 10-bit reading once stable, and tracks max / over-temperature.
//   temp_clk, reset_n   - clock, async active-low reset
//   enable              - run periodic reads
//   cs_n_1_4            - chip select to sensor (idle high, registered)
//   temp_data           - reading published by the sensor (same clock domain)
//   thr_hi, thr_lo      - over-temp set / clear thresholds
//   clr_max             - clear max_temp
//   sample, sample_vld  - last reading and its one-cycle update strobe
//   max_temp, over_temp - running maximum and hysteresis alarm
//   busy                - FSM not idle
module temp_sensor_reader
  import temp_pkg::*;
#(
  parameter int PERIOD_CYC = PERIOD_CYC_DEF,
  parameter int CS_LOW_CYC = CS_LOW_CYC_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic              temp_clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic              cs_n_1_4,
  input  logic [TEMP_W-1:0] temp_data,
  input  logic [TEMP_W-1:0] thr_hi,
  input  logic [TEMP_W-1:0] thr_lo,
  input  logic              clr_max,
  output logic [TEMP_W-1:0] sample,
  output logic              sample_vld,
  output logic [TEMP_W-1:0] max_temp,
  output logic              over_temp,
  output logic              busy
);

  localparam int PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int CS_W  = (CS_LOW_CYC > 1) ? $clog2(CS_LOW_CYC) : 1;
  localparam int STB_W = $clog2(STABLE_CNT + 1);

  localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(PERIOD_CYC - 1);
  localparam logic [PER_W-1:0] PER_ONE    = PER_W'(1);
  localparam logic [CS_W-1:0]  CS_RELOAD  = CS_W'(CS_LOW_CYC - 1);
  localparam logic [CS_W-1:0]  CS_ONE     = CS_W'(1);
  localparam logic [STB_W-1:0] STB_LAST   = STB_W'(STABLE_CNT - 1);
  localparam logic [STB_W-1:0] STB_ONE    = STB_W'(1);

  state_e             state_q, state_d;
  logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
  logic [CS_W-1:0]    cs_cnt_q, cs_cnt_d;
  logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [TEMP_W-1:0]  prev_q;
  logic               first_done_q, first_done_d;
  logic [TEMP_W-1:0]  sample_q, sample_d;
  logic               sample_vld_q, sample_vld_d;
  logic               cs_n_q, cs_n_d;
  logic               busy_q, busy_d;
  logic               not_ready_s;
  logic               cap_s;

  // A zero reading before any real capture means the sensor has not yet
  // completed its first conversion.
  assign not_ready_s = (temp_data == '0) && !first_done_q;
  assign cap_s       = (state_q == ST_CAPTURE) && !not_ready_s;

  // State and datapath registers.
  always_ff @(posedge temp_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      per_cnt_q    <= '0;
      cs_cnt_q     <= '0;
      stb_cnt_q    <= '0;
      prev_q       <= '0;
      first_done_q <= 1'b0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      cs_cnt_q     <= cs_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      prev_q       <= temp_data;
      first_done_q <= first_done_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
    end
  end

  // Next state and counters. The period counter only reloads on entry to a
  // wait, so it never wraps.
  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    cs_cnt_d  = cs_cnt_q;
    stb_cnt_d = stb_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_WAIT;
          per_cnt_d = PER_RELOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (per_cnt_q == '0) begin
          state_d   = ST_CHECK;
          stb_cnt_d = '0;
        end else begin
          per_cnt_d = per_cnt_q - PER_ONE;
        end
      end
      ST_CHECK: begin
        if (temp_data != prev_q) begin
          stb_cnt_d = '0;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d   = ST_CAPTURE;
          stb_cnt_d = '0;
        end else begin
          stb_cnt_d = stb_cnt_q + STB_ONE;
        end
      end
      ST_CAPTURE: begin
        if (not_ready_s) begin
          state_d   = ST_WAIT;
          per_cnt_d = PER_RELOAD;
        end else begin
          state_d  = ST_CS_LOW;
          cs_cnt_d = CS_RELOAD;
        end
      end
      ST_CS_LOW: begin
        // enable is deliberately ignored so the pulse is never truncated.
        if (cs_cnt_q == '0) begin
          state_d = ST_CS_HIGH;
        end else begin
          cs_cnt_d = cs_cnt_q - CS_ONE;
        end
      end
      ST_CS_HIGH: begin
        per_cnt_d = PER_RELOAD;
        if (enable) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so cs_n / busy line up with
  // the state they describe.
  always_comb begin
    cs_n_d       = (state_d != ST_CS_LOW);
    busy_d       = (state_d != ST_IDLE);
    sample_vld_d = cap_s;
    first_done_d = first_done_q | cap_s;
    if (cap_s) begin
      sample_d = temp_data;
    end else begin
      sample_d = sample_q;
    end
  end

  temp_hyst_track #(
    .W (TEMP_W)
  ) u_hyst (
    .clk_i        (temp_clk),
    .rst_n_i      (reset_n),
    .sample_i     (temp_data),
    .sample_vld_i (cap_s),
    .thr_hi_i     (thr_hi),
    .thr_lo_i     (thr_lo),
    .clr_max_i    (clr_max),
    .max_o        (max_temp),
    .over_o       (over_temp)
  );

  assign cs_n_1_4   = cs_n_q;
  assign sample     = sample_q;
  assign sample_vld = sample_vld_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Directed bench for temp_sensor_reader with PERIOD_CYC=16, CS_LOW_CYC=8,
// STABLE_CNT=2. Expected values below are hand-computed.
module tb_temp_sensor_reader;

  localparam int P        = 16;
  localparam int C        = 8;
  localparam int S        = 2;
  localparam int INTERVAL = P + S + C + 2;  // 28 cycles between strobes

  logic       temp_clk  = 1'b0;
  logic       reset_n   = 1'b0;
  logic       enable    = 1'b0;
  logic       clr_max   = 1'b0;
  logic [9:0] temp_data = 10'h000;
  logic [9:0] thr_hi    = 10'h200;
  logic [9:0] thr_lo    = 10'h1C0;
  logic       cs_n_1_4;
  logic [9:0] sample;
  logic       sample_vld;
  logic [9:0] max_temp;
  logic       over_temp;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [9:0] data;
    logic       clr;
    logic [9:0] exp_max;
    logic       exp_over;
  } vec_t;

  vec_t vecs [10];

  always #5 temp_clk = ~temp_clk;

  temp_sensor_reader #(
    .PERIOD_CYC (P),
    .CS_LOW_CYC (C),
    .STABLE_CNT (S)
  ) dut (
    .temp_clk   (temp_clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .cs_n_1_4   (cs_n_1_4),
    .temp_data  (temp_data),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .clr_max    (clr_max),
    .sample     (sample),
    .sample_vld (sample_vld),
    .max_temp   (max_temp),
    .over_temp  (over_temp),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge temp_clk);
    #1;
  endtask

  // Step until sample_vld (bounded). clr_max is pulsed for the edge after
  // step number clr_at. Returns steps taken and cs low samples seen.
  task automatic wait_vld(input int budget, input int clr_at, output int n, output int lows);
    n    = 0;
    lows = 0;
    while (n < budget) begin
      step();
      n++;
      if (!cs_n_1_4) lows++;
      if (sample_vld) break;
      if (n == clr_at) clr_max = 1'b1;
    end
    clr_max = 1'b0;
  endtask

  initial begin
    int n;
    int lows;
    int vlds;

    vecs[0] = '{10'h1F0, 1'b0, 10'h1F0, 1'b0};
    vecs[1] = '{10'h210, 1'b0, 10'h210, 1'b1};
    vecs[2] = '{10'h1D0, 1'b0, 10'h210, 1'b1};
    vecs[3] = '{10'h1B0, 1'b0, 10'h210, 1'b0};
    vecs[4] = '{10'h300, 1'b0, 10'h300, 1'b1};
    vecs[5] = '{10'h050, 1'b1, 10'h050, 1'b0};
    vecs[6] = '{10'h200, 1'b0, 10'h200, 1'b0};
    vecs[7] = '{10'h201, 1'b0, 10'h201, 1'b1};
    vecs[8] = '{10'h1C0, 1'b0, 10'h201, 1'b1};
    vecs[9] = '{10'h1BF, 1'b0, 10'h201, 1'b0};

    // Reset values.
    repeat (3) step();
    chk("rst cs_n", 32'(cs_n_1_4), 32'd1);
    chk("rst sample", 32'(sample), 32'd0);
    chk("rst vld", 32'(sample_vld), 32'd0);
    chk("rst max", 32'(max_temp), 32'd0);
    chk("rst over", 32'(over_temp), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    step();

    // Sensor not ready: zero reading before first capture, no pulse.
    enable    = 1'b1;
    temp_data = 10'h000;
    lows      = 0;
    vlds      = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (!cs_n_1_4) lows++;
      if (sample_vld) vlds++;
    end
    chk("notready cs lows", 32'(lows), 32'd0);
    chk("notready vlds", 32'(vlds), 32'd0);
    chk("notready busy", 32'(busy), 32'd1);
    temp_data = 10'h1A4;
    wait_vld(40, -1, n, lows);
    chk("restart latency", 32'(n), 32'd9);
    chk("first sample", 32'(sample), 32'h1A4);
    chk("first max", 32'(max_temp), 32'h1A4);
    chk("first over", 32'(over_temp), 32'd0);

    // Hysteresis / max table, steady-state pacing.
    for (int i = 0; i < 10; i++) begin
      temp_data = vecs[i].data;
      wait_vld(INTERVAL + 10, vecs[i].clr ? (INTERVAL - 1) : -1, n, lows);
      chk("interval", 32'(n), 32'(INTERVAL));
      chk("cs low width", 32'(lows), 32'(C));
      chk("sample", 32'(sample), 32'(vecs[i].data));
      chk("max", 32'(max_temp), 32'(vecs[i].exp_max));
      chk("over", 32'(over_temp), 32'(vecs[i].exp_over));
    end

    // Reading toggles through CHECK, then holds: capture delayed by 7.
    n = 0;
    while (n < 60) begin
      step();
      n++;
      if (sample_vld) break;
      if (n >= 20 && n <= 30) begin
        temp_data = (n % 2 == 1) ? 10'h101 : 10'h100;
      end else if (n > 30) begin
        temp_data = 10'h101;
      end
    end
    chk("unstable interval", 32'(n), 32'd35);
    chk("unstable sample", 32'(sample), 32'h101);
    chk("unstable max", 32'(max_temp), 32'h201);
    chk("unstable over", 32'(over_temp), 32'd0);

    // Standalone clr_max.
    clr_max = 1'b1;
    step();
    clr_max = 1'b0;
    chk("clr max", 32'(max_temp), 32'd0);

    // Next capture after clear; then drop enable on CS_LOW cycle 3.
    temp_data = 10'h0AA;
    wait_vld(INTERVAL + 10, -1, n, lows);
    chk("post clr interval", 32'(n), 32'(INTERVAL - 1));
    chk("post clr max", 32'(max_temp), 32'h0AA);
    lows = (cs_n_1_4 == 1'b0) ? 1 : 0;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (!cs_n_1_4) lows++;
      if (j == 2) enable = 1'b0;
      if (j == 8) chk("cs_high busy", 32'(busy), 32'd1);
      if (j == 9) begin
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle cs_n", 32'(cs_n_1_4), 32'd1);
      end
    end
    chk("drop cs low width", 32'(lows), 32'(C));
    vlds = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      if (sample_vld) vlds++;
    end
    chk("idle no vld", 32'(vlds), 32'd0);

    // Re-enable from IDLE: strobe P+S+2 edges later.
    enable = 1'b1;
    wait_vld(40, -1, n, lows);
    chk("enable latency", 32'(n), 32'(P + S + 2));
    chk("reenable sample", 32'(sample), 32'h0AA);

    // Reset mid-pulse: outputs return to reset values without a clock edge.
    step();
    step();
    chk("mid pulse cs_n", 32'(cs_n_1_4), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async cs_n", 32'(cs_n_1_4), 32'd1);
    chk("async sample", 32'(sample), 32'd0);
    chk("async vld", 32'(sample_vld), 32'd0);
    chk("async max", 32'(max_temp), 32'd0);
    chk("async over", 32'(over_temp), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
